div_share_ctrl: RTL

- Sequencing controller and two-port arbiter for the shared 4-bit sequential restoring divider datapath (ld/a/b in; ra/ry out).
- Accepts divide requests from two requesters over valid/ready and grants them round-robin.
- Drives the divider's load pulse, counts its iterations, and captures the quotient and remainder in exactly the correct cycle.
- Returns results over a per-requester valid/ready response channel. Divisors 0 and 1 are resolved locally without using the datapath.

---
 rtl/div_share_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/div_share_ctrl.sv
// Two-port round-robin front end and sequencer for a shared 4-bit
// restoring divider datapath; divisors 0 and 1 bypass the datapath.
module div_share_ctrl #(
    parameter int ITER    = 4,
    parameter int RR_INIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [3:0] req_a0,
    input  logic [3:0] req_b0,
    input  logic [3:0] req_a1,
    input  logic [3:0] req_b1,
    output logic [1:0] resp_valid,
    input  logic [1:0] resp_ready,
    output logic [3:0] resp_q,
    output logic [3:0] resp_r,
    output logic       resp_dz,
    output logic       busy,
    output logic       div_ld,
    output logic [3:0] div_a,
    output logic [3:0] div_b,
    input  logic [7:0] div_ra,
    input  logic [3:0] div_ry
);

    localparam int CW = $clog2(ITER + 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] RUN  = 3'd2;
    localparam logic [2:0] CAPT = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          rr;
    logic          owner;
    logic [1:0]    grant;
    logic          g_idx;
    logic [3:0]    sel_a;
    logic [3:0]    sel_b;
    logic          unused_ra;

    // Upper remainder bits carry the partial shift state only.
    assign unused_ra = ^div_ra[7:4];

    always_comb begin
        grant = 2'b00;
        if (state == IDLE) begin
            if (req_valid == 2'b11) begin
                grant = rr ? 2'b10 : 2'b01;
            end else begin
                grant = req_valid;
            end
        end
    end

    assign g_idx      = grant[1];
    assign sel_a      = g_idx ? req_a1 : req_a0;
    assign sel_b      = g_idx ? req_b1 : req_b0;
    assign req_ready  = grant & {2{rst}};
    assign busy       = (state != IDLE);
    assign div_ld     = (state == LOAD);
    assign resp_valid = (state == DONE) ? (owner ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rr      <= 1'(RR_INIT);
            owner   <= 1'b0;
            resp_q  <= 4'h0;
            resp_r  <= 4'h0;
            resp_dz <= 1'b0;
            div_a   <= 4'h0;
            div_b   <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        owner <= g_idx;
                        rr    <= ~g_idx;
                        if (sel_b == 4'd0) begin
                            resp_q  <= 4'hF;
                            resp_r  <= sel_a;
                            resp_dz <= 1'b1;
                            state   <= DONE;
                        end else if (sel_b == 4'd1) begin
                            resp_q  <= sel_a;
                            resp_r  <= 4'h0;
                            resp_dz <= 1'b0;
                            state   <= DONE;
                        end else begin
                            div_a <= sel_a;
                            div_b <= sel_b;
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    cnt   <= CW'(ITER);
                    state <= RUN;
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= CAPT;
                    end
                end
                // The datapath keeps shifting afterwards; this is the only valid cycle.
                CAPT: begin
                    resp_q  <= div_ry;
                    resp_r  <= div_ra[3:0];
                    resp_dz <= 1'b0;
                    state   <= DONE;
                end
                DONE: begin
                    if (resp_ready[owner]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
